// File: rtl/pwm_bound_calc.sv
// pwm_bound_calc
// Converts per-channel DUTY/PHASE into LEFT/RIGHT/OVER pulse edge bounds for
// the downstream PWM generators. One channel is issued per clock through a
// 3-stage pipeline; a full sweep runs once per UPDATE request.
//
// Build option: PWM_BOUND_SHADOW_EN
//   defined   - results collect in a shadow buffer and are committed to the
//               outputs all at once (latency TRANS_NUM+3).
//   undefined - results are written straight to the outputs as each channel
//               leaves the pipeline (latency TRANS_NUM+2).
//
// State table
//   state  | meaning
//   IDLE   | waiting for UPDATE
//   SWEEP  | issuing channel indices 0..TRANS_NUM-1, one per clock
//   DRAIN  | pipeline emptying after the last index
//   COMMIT | outputs updated, DONE pulsed; restart if a request is pending

module pwm_bound_calc #(
    parameter int WIDTH     = 13,
    parameter int TRANS_NUM = 249
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             update_i,
    input  logic [WIDTH-1:0] cycle_i [TRANS_NUM],
    input  logic [WIDTH-1:0] duty_i  [TRANS_NUM],
    input  logic [WIDTH-1:0] phase_i [TRANS_NUM],
    output logic [WIDTH-1:0] left_o  [TRANS_NUM],
    output logic [WIDTH-1:0] right_o [TRANS_NUM],
    output logic             over_o  [TRANS_NUM],
    output logic             busy_o,
    output logic             done_o
);

    localparam int IDX_W = (TRANS_NUM > 1) ? $clog2(TRANS_NUM) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TRANS_NUM - 1);

`ifdef PWM_BOUND_SHADOW_EN
    localparam int DRAIN_CYCLES = 2;
`else
    // Without the shadow buffer the final write coincides with the COMMIT
    // edge, so one drain cycle is enough.
    localparam int DRAIN_CYCLES = 1;
`endif
    localparam logic [1:0] DRAIN_LOAD = 2'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SWEEP  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [1:0]       drain_cnt_q;
    logic             pending_q;
    logic             busy_q;
    logic             done_q;

    // Stage 1 registers
    logic             s1_vld_q;
    logic [IDX_W-1:0] s1_idx_q;
    logic [WIDTH-1:0] s1_c_q;
    logic [WIDTH-1:0] s1_d_q;
    logic [WIDTH-1:0] s1_p_q;
    logic [WIDTH-1:0] sel_c;
    logic [WIDTH-1:0] sel_d;
    logic [WIDTH-1:0] sel_p;
    logic [WIDTH-1:0] s1_d_d;
    logic [WIDTH-1:0] s1_p_d;

    // Stage 2 registers
    logic                    s2_vld_q;
    logic [IDX_W-1:0]        s2_idx_q;
    logic [WIDTH-1:0]        s2_c_q;
    logic                    s2_zero_q;
    logic                    s2_full_q;
    logic signed [WIDTH+1:0] s2_l_q;
    logic signed [WIDTH+1:0] s2_r_q;
    logic signed [WIDTH+1:0] s2_l_d;
    logic signed [WIDTH+1:0] s2_r_d;

    // Stage 3 results
    logic signed [WIDTH+1:0] c_s;
    logic signed [WIDTH+1:0] l_w;
    logic signed [WIDTH+1:0] r_w;
    logic [WIDTH-1:0]        s3_l;
    logic [WIDTH-1:0]        s3_r;
    logic                    s3_o;

    // Output registers
    logic [WIDTH-1:0] left_q  [TRANS_NUM];
    logic [WIDTH-1:0] right_q [TRANS_NUM];
    logic             over_q  [TRANS_NUM];

    // Sweep sequencer: index issue, drain timer, pending request, BUSY/DONE
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            drain_cnt_q <= '0;
            pending_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (update_i) begin
                        state_q <= ST_SWEEP;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SWEEP: begin
                    if (update_i) pending_q <= 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_q     <= ST_DRAIN;
                        drain_cnt_q <= DRAIN_LOAD;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (update_i) pending_q <= 1'b1;
                    if (drain_cnt_q == 2'd0) begin
                        state_q <= ST_COMMIT;
                    end else begin
                        drain_cnt_q <= drain_cnt_q - 1'b1;
                    end
                end
                ST_COMMIT: begin
                    done_q <= 1'b1;
                    // A request seen during COMMIT restarts with no IDLE gap.
                    if (pending_q || update_i) begin
                        state_q   <= ST_SWEEP;
                        idx_q     <= '0;
                        pending_q <= 1'b0;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // S1 combinational: clamp duty to the period, fold phase into one period
    always_comb begin
        sel_c  = cycle_i[idx_q];
        sel_d  = duty_i[idx_q];
        sel_p  = phase_i[idx_q];
        s1_d_d = (sel_d >= sel_c) ? sel_c : sel_d;
        s1_p_d = (sel_p >= sel_c) ? (sel_p - sel_c) : sel_p;
    end

    // S1 register: sample the selected channel while sweeping
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_vld_q <= 1'b0;
            s1_idx_q <= '0;
            s1_c_q   <= '0;
            s1_d_q   <= '0;
            s1_p_q   <= '0;
        end else begin
            s1_vld_q <= (state_q == ST_SWEEP);
            if (state_q == ST_SWEEP) begin
                s1_idx_q <= idx_q;
                s1_c_q   <= sel_c;
                s1_d_q   <= s1_d_d;
                s1_p_q   <= s1_p_d;
            end
        end
    end

    // S2 combinational: unwrapped edges, floor(D/2) before and ceil(D/2) after
    always_comb begin
        s2_l_d = $signed({2'b00, s1_p_q}) - $signed({3'b000, s1_d_q[WIDTH-1:1]});
        s2_r_d = $signed({2'b00, s1_p_q}) + $signed({3'b000, s1_d_q[WIDTH-1:1]})
               + $signed({{(WIDTH+1){1'b0}}, s1_d_q[0]});
    end

    // S2 register: edges plus the always-low / always-high flags
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s2_vld_q  <= 1'b0;
            s2_idx_q  <= '0;
            s2_c_q    <= '0;
            s2_zero_q <= 1'b0;
            s2_full_q <= 1'b0;
            s2_l_q    <= '0;
            s2_r_q    <= '0;
        end else begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_idx_q  <= s1_idx_q;
                s2_c_q    <= s1_c_q;
                s2_zero_q <= (s1_d_q == '0);
                s2_full_q <= (s1_d_q == s1_c_q);
                s2_l_q    <= s2_l_d;
                s2_r_q    <= s2_r_d;
            end
        end
    end

    // S3 combinational: wrap edges into [0, CYCLE), detect wrap, apply overrides
    always_comb begin
        c_s  = $signed({2'b00, s2_c_q});
        l_w  = s2_l_q;
        r_w  = s2_r_q;
        if (s2_l_q[WIDTH+1]) l_w = s2_l_q + c_s;
        if (s2_r_q >= c_s)   r_w = s2_r_q - c_s;
        s3_l = l_w[WIDTH-1:0];
        s3_r = r_w[WIDTH-1:0];
        s3_o = (l_w > r_w);
        if (s2_zero_q) begin
            s3_l = '0;
            s3_r = '0;
            s3_o = 1'b0;
        end else if (s2_full_q) begin
            s3_l = '0;
            s3_r = s2_c_q;
            s3_o = 1'b0;
        end
    end

`ifdef PWM_BOUND_SHADOW_EN
    logic [WIDTH-1:0] left_sh_q  [TRANS_NUM];
    logic [WIDTH-1:0] right_sh_q [TRANS_NUM];
    logic             over_sh_q  [TRANS_NUM];

    // S3 write into the shadow entry for the channel leaving the pipeline
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < TRANS_NUM; i++) begin
                left_sh_q[i]  <= '0;
                right_sh_q[i] <= '0;
                over_sh_q[i]  <= 1'b0;
            end
        end else if (s2_vld_q) begin
            left_sh_q[s2_idx_q]  <= s3_l;
            right_sh_q[s2_idx_q] <= s3_r;
            over_sh_q[s2_idx_q]  <= s3_o;
        end
    end

    // Atomic commit of the whole shadow buffer
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < TRANS_NUM; i++) begin
                left_q[i]  <= '0;
                right_q[i] <= '0;
                over_q[i]  <= 1'b0;
            end
        end else if (state_q == ST_COMMIT) begin
            for (int i = 0; i < TRANS_NUM; i++) begin
                left_q[i]  <= left_sh_q[i];
                right_q[i] <= right_sh_q[i];
                over_q[i]  <= over_sh_q[i];
            end
        end
    end
`else
    // S3 write straight to the outputs, so channels update progressively
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < TRANS_NUM; i++) begin
                left_q[i]  <= '0;
                right_q[i] <= '0;
                over_q[i]  <= 1'b0;
            end
        end else if (s2_vld_q) begin
            left_q[s2_idx_q]  <= s3_l;
            right_q[s2_idx_q] <= s3_r;
            over_q[s2_idx_q]  <= s3_o;
        end
    end
`endif

    assign left_o  = left_q;
    assign right_o = right_q;
    assign over_o  = over_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule
